// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle controller
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN (enables the JAL path and ImmSrc=J).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:    return IMM_J;
`endif
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp, funct3, funct7b5 and op[5] to ALUControl
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only selects sub for R-type; addi reuses that bit as immediate
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM controller for a multicycle RISC-V datapath
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN (adds the JAL state; otherwise jal is illegal).
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [2:0]            ALUControl,
    output logic                  instr_done,
    output logic                  illegal
);

    state_e     state_q, state_d;
    logic [6:0] op;
    logic       illegal_c;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, done_c;
    logic       branch_c, pc_update_c;
    logic [1:0] alu_op_c;
    logic       unused_instr_bits;

    assign op = instr[6:0];
    assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:            state_d = S_JAL;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        AdrSrc      = ADR_PC;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        alu_op_c    = ALUOP_ADD;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        done_c      = 1'b0;
        branch_c    = 1'b0;
        pc_update_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                ir_write_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = ADR_RESULT;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = ADR_RESULT;
                mem_write_c = 1'b1;
                done_c      = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RD1;
                alu_op_c = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                alu_op_c = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_RD1;
                alu_op_c = ALUOP_SUB;
                branch_c = 1'b1;
                done_c   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pc_update_c = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pc_write_c = (state_q == S_FETCH) ? mem_ready : (pc_update_c | (branch_c & zero));

    // Reset holds FETCH, whose enables would otherwise follow mem_ready; mask them while low
    assign PCWrite    = rst_n & pc_write_c;
    assign IRWrite    = rst_n & ir_write_c;
    assign MemWrite   = rst_n & mem_write_c;
    assign RegWrite   = rst_n & reg_write_c;
    assign instr_done = rst_n & done_c;
    assign illegal    = rst_n & illegal_c;
    assign ImmSrc     = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_c),
        .funct3_i      (instr[14:12]),
        .funct7b5_i    (instr[30]),
        .op5_i         (op[5]),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (honours MULTICYCLE_CTRL_JAL_EN)
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       done;
        logic       ill;
    } ctl_t;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                      P_EXR, P_EXI, P_ALUWB, P_BEQ, P_JAL} ph_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    ctl_t        act;

    ctl_t  exp_q[$];
    string name_q[$];
    int    lat_q[$];
    int    checks = 0;
    int    passed = 0;
    int    mcyc = 0;
    string ph_names[11] = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB", "MEMWRITE",
                            "EXECUTER", "EXECUTEI", "ALUWB", "BEQ", "JAL"};

    multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always_comb act = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                       ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    endtask

    // Instruction class from opcode: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
    function automatic int kind(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return JAL_EN ? 5 : 6;
            default:    return 6;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [31:0] ins);
        case (kind(ins))
            1: return 2'b01;
            4: return 2'b10;
            5: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // add/sub/and/or/xor/slt semantic codes; sub only for R-type with bit 30 set
    function automatic logic [2:0] exp_alu(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (kind(ins) == 2 && ins[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t expect_of(input ph_e p, input logic [31:0] ins, input logic mr, input logic z);
        ctl_t e;
        e = '0;
        e.imm = exp_imm(ins);
        case (p)
            P_FETCH:  begin e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            P_DECODE: begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = (kind(ins) == 6); end
            P_MEMADR: begin e.srca = 2'b10; e.srcb = 2'b01; end
            P_MEMRD:  e.adr = 1'b1;
            P_MEMWB:  begin e.res = 2'b01; e.regw = 1'b1; e.done = 1'b1; end
            P_MEMWR:  begin e.adr = 1'b1; e.memw = 1'b1; e.done = mr; end
            P_EXR:    begin e.srca = 2'b10; e.aluc = exp_alu(ins); end
            P_EXI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = exp_alu(ins); end
            P_ALUWB:  begin e.regw = 1'b1; e.done = 1'b1; end
            P_BEQ:    begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; e.done = 1'b1; end
            P_JAL:    begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
            default:  ;
        endcase
        return e;
    endfunction

    function automatic int latency(input int k, input int fst, input int mst);
        case (k)
            0: return fst + 5 + mst;
            1: return fst + 4 + mst;
            2, 3, 5: return fst + 4;
            4: return fst + 3;
            default: return fst + 2;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            default: begin
                do op = 7'($urandom);
                while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111});
            end
        endcase
        r[6:0] = op;
        return r;
    endfunction

    task automatic step(input ph_e p, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        exp_q.push_back(expect_of(p, instr, mr, z));
        name_q.push_back(ph_names[p]);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // zb < 0 means random zero flag in BEQ
    task automatic run_instr(input logic [31:0] ins, input int fst, input int mst, input int zb);
        int k;
        k = kind(ins);
        instr = ins;
        lat_q.push_back(latency(k, fst, mst));
        for (int i = 0; i < fst; i++) step(P_FETCH, 1'b0, rb());
        step(P_FETCH, 1'b1, rb());
        step(P_DECODE, rb(), rb());
        case (k)
            0: begin
                step(P_MEMADR, rb(), rb());
                for (int i = 0; i < mst; i++) step(P_MEMRD, 1'b0, rb());
                step(P_MEMRD, 1'b1, rb());
                step(P_MEMWB, rb(), rb());
            end
            1: begin
                step(P_MEMADR, rb(), rb());
                for (int i = 0; i < mst; i++) step(P_MEMWR, 1'b0, rb());
                step(P_MEMWR, 1'b1, rb());
            end
            2: begin step(P_EXR, rb(), rb()); step(P_ALUWB, rb(), rb()); end
            3: begin step(P_EXI, rb(), rb()); step(P_ALUWB, rb(), rb()); end
            4: step(P_BEQ, rb(), (zb < 0) ? rb() : logic'(zb));
            5: begin step(P_JAL, rb(), rb()); step(P_ALUWB, rb(), rb()); end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mcyc = 0;
        end else begin
            mcyc++;
            if (exp_q.size() > 0) check(name_q.pop_front(), 32'(act), 32'(exp_q.pop_front()));
            if (instr_done || illegal) begin
                if (lat_q.size() > 0) check("latency", mcyc, lat_q.pop_front());
                else check("unexpected_done", 32'({instr_done, illegal}), 32'h0);
                mcyc = 0;
            end
        end
    end

    initial begin
        ctl_t rexp;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        instr = 32'h002081B3;
        #12;
        rexp = '0;
        rexp.srcb = 2'b10;
        rexp.res = 2'b10;
        check("reset_outputs", 32'(act), 32'(rexp));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(32'h002081B3, 0, 0, -1);
        run_instr(32'h00402283, 0, 2, -1);
        run_instr(32'h00502423, 0, 0, -1);
        run_instr(32'h00000463, 0, 0, 1);
        run_instr(32'h00000463, 0, 0, 0);
        run_instr(32'h010000EF, 0, 0, -1);

        // Abort a store while it waits in MEMWRITE
        instr = 32'h00502423;
        step(P_FETCH, 1'b1, 1'b0);
        step(P_DECODE, 1'b0, 1'b0);
        step(P_MEMADR, 1'b0, 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(expect_of(P_MEMWR, instr, 1'b0, 1'b0));
        name_q.push_back("MEMWRITE_held");
        @(negedge clk);
        #1;
        check("memwrite_before_reset", 32'(MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        check("memwrite_async_drop", 32'(MemWrite), 32'h0);
        mem_ready = 1'b1;
        #1;
        rexp = '0;
        rexp.srcb = 2'b10;
        rexp.res = 2'b10;
        rexp.imm = 2'b01;
        check("reset_mid_store", 32'(act), 32'(rexp));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(32'h002081B3, 0, 0, -1);

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                      $urandom_range(0, 3), -1);

        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        check("lat_queue_drained", lat_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port instr, input, DATA_WIDTH bits: instruction-register contents; op=[6:0], funct3=[14:12], funct7b5=[30].
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: the memory access this cycle completes.
REQ-007 SHALL have ports PCWrite, AdrSrc, IRWrite, MemWrite and RegWrite, each output, 1 bit.
REQ-008 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, each output, 2 bits.
REQ-009 SHALL have port ALUControl, output, 3 bits.
REQ-010 SHALL have ports instr_done and illegal, each output, 1 bit: single-cycle pulses.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-012 SHALL use these encodings: AdrSrc 0=PC, 1=Result; ALUSrcA 00=PC, 01=OldPC, 10=RD1; ALUSrcB 00=RD2, 01=Imm, 10=4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10 and ALUOp=add; IRWrite and PCWrite SHALL assert only while mem_ready=1; it SHALL hold in FETCH while mem_ready=0.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01 and ALUOp=add.
REQ-014a DECODE SHALL transition on op as follows: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH with illegal=1 for one cycle.
REQ-015 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOp=add, then go to MEMREAD if op[5]=0, else MEMWRITE.
REQ-016 MEMREAD SHALL drive ResultSrc=00 and AdrSrc=1, and hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-018 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1 and MemWrite=1, and hold until mem_ready=1, then go to FETCH; MemWrite SHALL stay high for every held cycle.
REQ-019 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00 and ALUOp=funct; EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOp=funct; both SHALL go to ALUWB.
REQ-020 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-021 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ResultSrc=00 and ALUOp=sub, with Branch=1; it SHALL go to FETCH.
REQ-022 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=00 and ALUOp=add, with PCUpdate=1; it SHALL go to ALUWB.
REQ-023 PCWrite SHALL equal (PCUpdate | (Branch & zero)), with the FETCH qualification of REQ-013 applied.
REQ-024 ImmSrc SHALL be combinational from op: I-type=00, S=01, B=10, J=11; don't-care states SHALL drive 00.
REQ-025 instr_done SHALL pulse in the final state of every instruction: MEMWB, MEMWRITE (with mem_ready=1), ALUWB and BEQ.
REQ-026 Latency with mem_ready always high SHALL be: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
REQ-027 All outputs not listed for a state SHALL be 0.

Reset
REQ-028 Asserting rst_n low SHALL force state=FETCH immediately, regardless of clk.
REQ-029 During reset, all write enables and both pulses SHALL be 0.
REQ-030 Reset asserted mid-instruction SHALL abandon it with no partial write after deassertion.
REQ-031 The first cycle after deassertion SHALL be FETCH.

Configuration
REQ-032 With macro MULTICYCLE_CTRL_JAL_EN defined, the JAL state and path SHALL exist.
REQ-033 With MULTICYCLE_CTRL_JAL_EN undefined, op 1101111 SHALL take the illegal path of REQ-014a, and ImmSrc=11 SHALL never be driven.

Structure
REQ-034 Package ctrl_pkg SHALL hold the state enum, opcode constants, ALUOp encoding (00 add, 01 sub, 10 funct) and the select encodings.
REQ-035 The existing alu_decoder SHALL be instantiated as the sole sub-module, mapping ALUOp, funct3, funct7b5 and op[5] to ALUControl.

Verification
REQ-036 Bench SHALL cover: add x3,x1,x2 (0x002081B3), mem_ready=1 -> RegWrite=1 in cycle 4; instr_done in cycle 4; ALUControl=000 in EXECUTER.
REQ-037 Bench SHALL cover: lw x5,4(x0) (0x00402283), mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; RegWrite with ResultSrc=01 in the last cycle.
REQ-038 Bench SHALL cover: sw x5,8(x0) (0x00502423) -> MemWrite=1 only in MEMWRITE; ImmSrc=01; RegWrite never high.
REQ-039 Bench SHALL cover: beq x0,x0,8 (0x00000463) with zero=1 -> PCWrite=1 in cycle 3; with zero=0 -> PCWrite=0 in cycle 3.
REQ-040 Bench SHALL cover: jal x1,16 (0x010000EF) -> JAL then ALUWB, ImmSrc=11; without the macro -> illegal pulse, then FETCH.
REQ-041 Bench SHALL cover: rst_n low mid-MEMWRITE -> MemWrite drops asynchronously; FETCH on release.
